// File: rtl/ysyx_22040386_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040386_lsu_pkg
//  Description : Shared definitions for the multi-cycle load/store unit:
//                access-size encodings, controller state encoding and the
//                position of the zero-extend flag inside mask_type.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_22040386_lsu_pkg;

    // Access size, mask_type[1:0]
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // mask_type[ZEXT] = 1 selects zero extension of load data
    localparam int ZEXT = 2;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

endpackage : ysyx_22040386_lsu_pkg
`default_nettype wire

// File: rtl/ysyx_22040386_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040386_lsu_align
//  Description : Purely combinational lane alignment for an 8-lane data bus.
//                Flags misaligned accesses, builds the store byte mask and
//                lane-shifted store data, and extracts/extends load data.
//  Ports       : size_i     access size (SZ_B/H/W/D)
//                zext_i     1 = zero-extend load data
//                off_i      byte offset within the 8-byte word
//                wdata_i    right-justified store data
//                rdata_i    raw 8-byte-aligned read word
//                misalign_o access crosses its natural alignment
//                wmask_o    byte-enable mask
//                wdata_o    store data shifted into its lanes
//                rdata_o    extended load data
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22040386_lsu_align
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [1:0]        size_i,
    input  logic              zext_i,
    input  logic [2:0]        off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              misalign_o,
    output logic [7:0]        wmask_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [5:0]        w_shamt;
    logic [DATA_W-1:0] w_rshift;

    // Byte offset converted to a bit shift amount
    assign w_shamt  = {off_i, 3'b000};
    assign wdata_o  = wdata_i << w_shamt;
    // Bring the addressed lane down to bit 0 before extension
    assign w_rshift = rdata_i >> w_shamt;

    always_comb begin
        misalign_o = 1'b0;
        wmask_o    = 8'h00;
        rdata_o    = '0;
        unique case (size_i)
            SZ_B: begin
                wmask_o = 8'h01 << off_i;
                rdata_o = {{(DATA_W-8){w_rshift[7] & ~zext_i}}, w_rshift[7:0]};
            end
            SZ_H: begin
                misalign_o = off_i[0];
                wmask_o    = 8'h03 << off_i;
                rdata_o    = {{(DATA_W-16){w_rshift[15] & ~zext_i}}, w_rshift[15:0]};
            end
            SZ_W: begin
                misalign_o = |off_i[1:0];
                wmask_o    = 8'h0F << off_i;
                rdata_o    = {{(DATA_W-32){w_rshift[31] & ~zext_i}}, w_rshift[31:0]};
            end
            SZ_D: begin
                misalign_o = |off_i;
                wmask_o    = 8'hFF;
                rdata_o    = rdata_i;
            end
        endcase
    end

endmodule : ysyx_22040386_lsu_align
`default_nettype wire

// File: rtl/ysyx_22040386_lsu_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22040386_lsu_fsm
//  Description : Multi-cycle load/store controller between EXU and the data
//                memory port. One access outstanding at a time; valid/ready
//                on the EXU side, memory request and response side, and the
//                WBU result side.
//  Ports       : clk, rst_n                      clock, async active-low reset
//                in_valid/in_ready, in_mem_read, in_mem_write, in_mask_type,
//                in_addr, in_wdata, in_rd        access from EXU
//                mem_req_valid/ready, mem_req_we, mem_req_addr,
//                mem_req_wdata, mem_req_wmask    memory request
//                mem_rsp_valid, mem_rsp_rdata    memory response
//                out_valid/out_ready, out_rdata, out_rd, out_is_load,
//                out_misalign                    result to WBU
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22040386_lsu_fsm
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // EXU side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [2:0]        in_mask_type,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic [4:0]        in_rd,
    // Memory request
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [7:0]        mem_req_wmask,
    // Memory response
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_rdata,
    // WBU side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rdata,
    output logic [4:0]        out_rd,
    output logic              out_is_load,
    output logic              out_misalign
);

    lsu_state_e state_q, state_d;

    logic [ADDR_W-4:0] addr_hi_q;
    logic [2:0]        off_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic              we_q;
    logic              is_load_q;
    logic              misalign_q;
    logic [4:0]        rd_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;
    logic [DATA_W-1:0] rdata_q;

    logic              w_idle;
    logic              w_accept;
    logic              w_access;
    logic              w_fault;
    logic [1:0]        w_al_size;
    logic              w_al_zext;
    logic [2:0]        w_al_off;
    logic              w_al_misalign;
    logic [7:0]        w_al_wmask;
    logic [DATA_W-1:0] w_al_wdata;
    logic [DATA_W-1:0] w_al_rdata;

    assign w_idle   = (state_q == LSU_IDLE);
    assign w_accept = in_valid && w_idle;
    assign w_access = in_mem_read || in_mem_write;
    // A no-op carries no size, so it can never fault
    assign w_fault  = w_access && w_al_misalign;

    // The aligner serves the incoming access while idle (misalign, mask,
    // store data) and the captured access afterwards (load extraction).
    assign w_al_size = w_idle ? in_mask_type[1:0]  : size_q;
    assign w_al_zext = w_idle ? in_mask_type[ZEXT] : zext_q;
    assign w_al_off  = w_idle ? in_addr[2:0]       : off_q;

    ysyx_22040386_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .size_i     (w_al_size),
        .zext_i     (w_al_zext),
        .off_i      (w_al_off),
        .wdata_i    (in_wdata),
        .rdata_i    (mem_rsp_rdata),
        .misalign_o (w_al_misalign),
        .wmask_o    (w_al_wmask),
        .wdata_o    (w_al_wdata),
        .rdata_o    (w_al_rdata)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LSU_IDLE: begin
                if (w_accept) begin
                    // Faults and no-ops skip memory but still produce a
                    // result so the WBU sees them in program order.
                    if (w_fault || !w_access) begin
                        state_d = LSU_RESP;
                    end else begin
                        state_d = LSU_REQ;
                    end
                end
            end
            LSU_REQ: begin
                if (mem_req_ready) begin
                    state_d = LSU_WAIT;
                end
            end
            LSU_WAIT: begin
                if (mem_rsp_valid) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                if (out_ready) begin
                    state_d = LSU_IDLE;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Access capture and load-data latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi_q  <= '0;
            off_q      <= '0;
            size_q     <= '0;
            zext_q     <= 1'b0;
            we_q       <= 1'b0;
            is_load_q  <= 1'b0;
            misalign_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
        end else if (w_accept) begin
            addr_hi_q  <= in_addr[ADDR_W-1:3];
            off_q      <= in_addr[2:0];
            size_q     <= in_mask_type[1:0];
            zext_q     <= in_mask_type[ZEXT];
            // Read+write together is treated as a store
            we_q       <= in_mem_write;
            is_load_q  <= in_mem_read && !in_mem_write;
            misalign_q <= w_fault;
            rd_q       <= in_rd;
            wdata_q    <= w_al_wdata;
            wmask_q    <= w_al_wmask;
            // Cleared here so stores, no-ops and faults report zero
            rdata_q    <= '0;
        end else if ((state_q == LSU_WAIT) && mem_rsp_valid && !we_q) begin
            rdata_q    <= w_al_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready      = w_idle;
    assign mem_req_valid = (state_q == LSU_REQ);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = {addr_hi_q, 3'b000};
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

    assign out_valid     = (state_q == LSU_RESP);
    assign out_rdata     = rdata_q;
    assign out_rd        = rd_q;
    assign out_is_load   = is_load_q;
    assign out_misalign  = misalign_q;

endmodule : ysyx_22040386_lsu_fsm
`default_nettype wire

// File: tb/tb_ysyx_22040386_lsu_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_ysyx_22040386_lsu_fsm
//  Description : Self-checking bench for the load/store controller. A table
//                of accesses is run against a byte-addressed memory model;
//                expected results go to a scoreboard queue at drive time and
//                are compared at the output handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_22040386_lsu_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mem_read = 1'b0;
    logic        in_mem_write = 1'b0;
    logic [2:0]  in_mask_type = 3'b000;
    logic [63:0] in_addr = 64'h0;
    logic [63:0] in_wdata = 64'h0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rsp_rdata = 64'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_is_load;
    logic        out_misalign;

    always #5 clk = ~clk;

    ysyx_22040386_lsu_fsm #(
        .ADDR_W (64),
        .DATA_W (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .in_mask_type  (in_mask_type),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_rd         (in_rd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_rd        (out_rd),
        .out_is_load   (out_is_load),
        .out_misalign  (out_misalign)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  mt;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        pre;        // preload the memory word before the access
        logic [63:0] pre_data;
        logic        exp_mis;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_wdata;
        logic [63:0] exp_rdata;
        int          stall;      // cycles mem_req_ready is held low
        int          rdly;       // extra cycles before the response
        int          odly;       // cycles out_ready is held low
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        is_load;
        logic        mis;
    } res_t;

    vec_t        vecs[$];
    res_t        sbq[$];
    logic [63:0] mem [logic [60:0]];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [4:0] tag);
        bit          is_mem;
        bit          pend;
        bit          done;
        int          exp_ov;
        int          cyc;
        int          scnt;
        int          rcnt;
        int          ocnt;
        int          ov_cyc;
        int          rsp_cyc;
        logic [60:0] k;
        logic [63:0] w;
        logic [63:0] rsp_word;
        res_t        e;
        res_t        q;

        is_mem   = (v.rd || v.wr) && !v.exp_mis;
        exp_ov   = is_mem ? (3 + v.stall + v.rdly) : 1;
        pend     = 1'b0;
        done     = 1'b0;
        scnt     = 0;
        rcnt     = 0;
        ocnt     = 0;
        ov_cyc   = -1;
        rsp_cyc  = -1;
        rsp_word = 64'h0;
        if (v.pre) mem[v.addr[63:3]] = v.pre_data;

        e.rdata   = v.exp_rdata;
        e.rd      = tag;
        e.is_load = v.rd && !v.wr;
        e.mis     = v.exp_mis;
        sbq.push_back(e);

        chk("in_ready_idle", in_ready, 1);
        in_valid     = 1'b1;
        in_mem_read  = v.rd;
        in_mem_write = v.wr;
        in_mask_type = v.mt;
        in_addr      = v.addr;
        in_wdata     = v.wdata;
        in_rd        = tag;
        @(negedge clk);
        // Scramble the inputs: the DUT must work from its captured copy
        in_valid     = 1'b0;
        in_mem_read  = ~v.rd;
        in_mem_write = ~v.wr;
        in_mask_type = ~v.mt;
        in_addr      = ~v.addr;
        in_wdata     = ~v.wdata;
        in_rd        = ~tag;
        cyc = 1;

        while (!done && cyc < 80) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
            if (pend) begin
                if (rcnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_rdata = rsp_word;
                    pend          = 1'b0;
                    rsp_cyc       = cyc;
                end else begin
                    rcnt--;
                end
            end

            if (!is_mem) begin
                chk("no_mem_req", mem_req_valid, 0);
                mem_req_ready = 1'b0;
            end else if (mem_req_valid) begin
                chk("req_addr", mem_req_addr, {v.addr[63:3], 3'b000});
                chk("req_we", mem_req_we, v.wr);
                if (v.wr) begin
                    chk("req_wmask", mem_req_wmask, v.exp_wmask);
                    chk("req_wdata", mem_req_wdata, v.exp_wdata);
                end
                if (scnt < v.stall) begin
                    mem_req_ready = 1'b0;
                    // Stray response while the request is pending must be ignored
                    if (scnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
                    end
                    scnt++;
                end else begin
                    mem_req_ready = 1'b1;
                    k = mem_req_addr[63:3];
                    w = mem.exists(k) ? mem[k] : 64'h0;
                    if (mem_req_we) begin
                        for (int i = 0; i < 8; i++) begin
                            if (mem_req_wmask[i]) w[i*8 +: 8] = mem_req_wdata[i*8 +: 8];
                        end
                        mem[k]   = w;
                        rsp_word = 64'hBAD0_BAD0_BAD0_BAD0;
                    end else begin
                        rsp_word = w;
                    end
                    pend = 1'b1;
                    rcnt = v.rdly;
                end
            end else begin
                mem_req_ready = 1'b0;
            end

            if (out_valid) begin
                if (ov_cyc < 0) begin
                    ov_cyc = cyc;
                    chk("out_latency", cyc, exp_ov);
                    if (is_mem) chk("rsp_to_out", cyc - rsp_cyc, 1);
                end
                chk("in_ready_resp", in_ready, 0);
                if (ocnt < v.odly) begin
                    out_ready = 1'b0;
                    chk("hold_rdata", out_rdata, e.rdata);
                    chk("hold_rd", out_rd, e.rd);
                    chk("hold_mis", out_misalign, e.mis);
                    ocnt++;
                end else begin
                    out_ready = 1'b1;
                    if (sbq.size() > 0) begin
                        q = sbq.pop_front();
                        chk("out_rdata", out_rdata, q.rdata);
                        chk("out_rd", out_rd, q.rd);
                        chk("out_is_load", out_is_load, q.is_load);
                        chk("out_misalign", out_misalign, q.mis);
                    end
                    done = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: access %0d got no result, expected out_valid by cycle %0d", tag, exp_ov);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                 rd    wr    mt      addr                   wdata                  pre   pre_data               mis   wmask  exp_wdata              exp_rdata              stl rd od
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'h0,                 1'b1, 64'h0000_80FF_0000_0000, 1'b0, 8'h00, 64'h0,                 64'h0,                 0, 0, 0}); // lb, byte 3 = 0x00
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0003, 64'h0,                 1'b1, 64'h0000_0000_8000_0000, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 0, 1, 0}); // lb 0x80
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b100, 64'h0000_0000_8000_0003, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_0080, 1, 0, 0}); // lbu 0x80
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_0006, 64'h0000_0000_0000_1234, 1'b0, 64'h0,               1'b0, 8'hC0, 64'h1234_0000_0000_0000, 64'h0,                 0, 2, 1}); // sh
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0002, 64'h0,                 1'b0, 64'h0,                 1'b1, 8'h00, 64'h0,                 64'h0,                 0, 0, 0}); // lw misaligned
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0006, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_1234, 5, 3, 4}); // lh, slow memory + WBU stall
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b101, 64'h0000_0000_8000_0004, 64'h0,                 1'b1, 64'h0000_8001_0000_0000, 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_8001, 0, 0, 0}); // lhu
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0004, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 0, 0, 0}); // lh negative
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b010, 64'h0000_0000_8000_0004, 64'h0,                 1'b1, 64'h8765_4321_0000_0000, 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 0, 0, 0}); // lw
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b110, 64'h0000_0000_8000_0004, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0000_0000_8765_4321, 0, 0, 0}); // lwu
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b000, 64'h0000_0000_8000_0005, 64'h0000_0000_0000_00AB, 1'b0, 64'h0,               1'b0, 8'h20, 64'h0000_AB00_0000_0000, 64'h0,                 0, 0, 0}); // sb
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0005, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FFAB, 0, 0, 0}); // lb after sb
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b010, 64'h0000_0000_8000_0004, 64'h0000_0000_DEAD_BEEF, 1'b0, 64'h0,               1'b0, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0,                 0, 0, 0}); // sw
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0004, 64'h0,                 1'b0, 64'h0,                 1'b1, 8'h00, 64'h0,                 64'h0,                 0, 0, 0}); // ld misaligned
        vecs.push_back(vec_t'{1'b0, 1'b1, 3'b001, 64'h0000_0000_8000_0001, 64'h0000_0000_0000_5555, 1'b0, 64'h0,               1'b1, 8'h00, 64'h0,                 64'h0,                 0, 0, 1}); // sh misaligned
        vecs.push_back(vec_t'{1'b0, 1'b0, 3'b000, 64'h0000_0000_8000_0008, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0,                 0, 0, 0}); // no-op
        vecs.push_back(vec_t'{1'b1, 1'b1, 3'b011, 64'h0000_0000_8000_0010, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0,               1'b0, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0,                 0, 0, 0}); // rd+wr => sd
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b011, 64'h0000_0000_8000_0010, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF, 0, 0, 0}); // ld back-to-back
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0017, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'h0000_0000_0000_0001, 0, 0, 0}); // lb top lane
        vecs.push_back(vec_t'{1'b1, 1'b0, 3'b001, 64'h0000_0000_8000_0012, 64'h0,                 1'b0, 64'h0,                 1'b0, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_89AB, 0, 0, 0}); // lh lane 2

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_rdata", out_rdata, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_is_load", out_is_load, 0);
        chk("rst_out_misalign", out_misalign, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 5'(i + 1));
        end

        // Reset while waiting for the memory response, then a stray response
        in_valid     = 1'b1;
        in_mem_read  = 1'b1;
        in_mem_write = 1'b0;
        in_mask_type = 3'b011;
        in_addr      = 64'h0000_0000_8000_0010;
        in_rd        = 5'd30;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstseq_req_valid", mem_req_valid, 1);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("rstseq_wait_req", mem_req_valid, 0);
        chk("rstseq_wait_out", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rstseq_async_in_ready", in_ready, 1);
        chk("rstseq_async_req", mem_req_valid, 0);
        chk("rstseq_async_out", out_valid, 0);
        chk("rstseq_async_rd", out_rd, 0);
        @(negedge clk);
        rst_n         = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstseq_stray_out", out_valid, 0);
            chk("rstseq_stray_in_ready", in_ready, 1);
            chk("rstseq_stray_rdata", out_rdata, 0);
            @(negedge clk);
        end
        run_vec(vecs[17], 5'd31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ysyx_22040386_lsu_fsm
`default_nettype wire
